// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state codes and protocol constants for the USB transmit encoder
package usb_tx_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_EOP_SE0 = 3'd3;
  localparam logic [2:0] ST_EOP_J   = 3'd4;
  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         STUFF_LIMIT  = 6;
  localparam int         EOP_SE0_BITS = 2;
endpackage

// File: rtl/usb_tx_bit_timer.sv
// usb_tx_bit_timer: divides clk into USB bit times, strobing on the last cycle of each bit
module usb_tx_bit_timer #(
  parameter int BIT_CLKS = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  output logic o_bit_strobe
);
  logic [3:0] r_count;
  assign o_bit_strobe = !i_clear && r_count == 4'(BIT_CLKS - 1);
  // free-running 0..BIT_CLKS-1 count, parked at zero while the line is idle
  always_ff @(posedge clk) begin
    if (n_rst || i_clear) r_count <= 4'd0;
    else r_count <= o_bit_strobe ? 4'd0 : r_count + 4'd1;
  end
endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB packet serializer with SYNC, bit stuffing, NRZI and EOP
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int BIT_CLKS = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       tx_data_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       dplus_out,
  output logic       dminus_out
);
  logic [2:0] r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [2:0] r_ones;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       r_hold_last;
  logic       r_cur_last;
  logic       r_err;
  logic       r_line;
  logic       r_se0;
  logic       r_done;
  logic       r_error;
  logic       w_strobe;
  logic       w_shifting;
  logic       w_stuff;
  logic       w_mid;
  logic       w_load;
  logic       w_bit;
  logic       w_accept;

  usb_tx_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_clear      (r_state == ST_IDLE),
    .o_bit_strobe (w_strobe)
  );

  // SYNC and DATA share one shifter: SYNC is just a preloaded byte that never ends a packet
  assign w_shifting = r_state == ST_SYNC || r_state == ST_DATA;
  assign w_stuff    = r_ones == 3'(STUFF_LIMIT);
  assign w_mid      = r_bit_cnt != 3'd7;
  assign w_load     = !w_stuff && !w_mid && (r_state == ST_SYNC || !r_cur_last) && r_hold_full;
  assign w_bit      = w_stuff ? 1'b0 : w_mid ? r_shift[r_bit_cnt + 3'd1] : r_hold[0];
  assign w_accept   = tx_data_valid && !r_hold_full;

  assign tx_data_ready = !r_hold_full;
  assign tx_busy       = r_state != ST_IDLE;
  assign tx_done       = r_done;
  assign tx_error      = r_error;
  assign dplus_out     = !r_se0 && r_line;
  assign dminus_out    = !r_se0 && !r_line;

  // one-byte holding register between upstream and the shifter
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= tx_data;
      r_hold_full <= 1'b1;
      r_hold_last <= tx_last;
    end else if (w_strobe && w_shifting && w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // packet sequencer: picks the next line symbol at every bit boundary
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= 8'd0;
      r_bit_cnt  <= 3'd0;
      r_ones     <= 3'd0;
      r_cur_last <= 1'b0;
      r_err      <= 1'b0;
      r_line     <= 1'b1;
      r_se0      <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (tx_start) begin
          r_state    <= ST_SYNC;
          r_shift    <= SYNC_BYTE;
          r_bit_cnt  <= 3'd0;
          r_ones     <= {2'd0, SYNC_BYTE[0]};
          r_line     <= SYNC_BYTE[0];
          r_cur_last <= 1'b0;
          r_err      <= 1'b0;
        end
      end else if (w_strobe) begin
        if (w_shifting) begin
          if (w_stuff || w_mid || w_load) begin
            r_line <= w_bit ? r_line : !r_line;
            r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
            if (w_mid && !w_stuff) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_load) begin
              r_shift    <= r_hold;
              r_bit_cnt  <= 3'd0;
              r_cur_last <= r_hold_last;
              r_state    <= ST_DATA;
            end
          end else begin
            r_state   <= ST_EOP_SE0;
            r_se0     <= 1'b1;
            r_bit_cnt <= 3'd0;
            r_err     <= !(r_state == ST_DATA && r_cur_last);
          end
        end else if (r_state == ST_EOP_SE0) begin
          if (r_bit_cnt == 3'(EOP_SE0_BITS - 1)) begin
            r_state <= ST_EOP_J;
            r_se0   <= 1'b0;
            r_line  <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end else begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
          r_error <= r_err;
          r_err   <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: table, hand-written and random packets checked against a bit-level line model
module tb_usb_tx_encoder;
  localparam int BK = 8;
  typedef struct {
    string      name;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         nsend;
    int         cyc;
    logic       err;
    bit         bstart;
  } vec_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_data_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_data_ready, tx_busy, tx_done, tx_error, dplus_out, dminus_out;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] pkt[8];
  logic [1:0] exp_q[$];
  vec_t       vt[9];

  usb_tx_encoder #(.BIT_CLKS(BK)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_last       (tx_last),
    .tx_data_ready (tx_data_ready),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_error      (tx_error),
    .dplus_out     (dplus_out),
    .dminus_out    (dminus_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, req);
  endtask

  // expected line symbols per bit time: {dplus,dminus}, J=10 K=01 SE0=00
  function automatic void build(input int nsend);
    logic lvl;
    int   ones;
    bit   b;
    exp_q.delete();
    lvl  = 1'b1;
    ones = 0;
    for (int i = 0; i < 8 + 8 * nsend; i++) begin
      b = (i < 8) ? (i == 7) : pkt[(i - 8) / 8][(i - 8) % 8];
      if (b) ones++;
      else begin
        ones = 0;
        lvl  = ~lvl;
      end
      exp_q.push_back({lvl, ~lvl});
      if (ones == 6) begin
        ones = 0;
        lvl  = ~lvl;
        exp_q.push_back({lvl, ~lvl});
      end
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endfunction

  task automatic run_packet(input string name, input int n, input int nsend, input int cyc,
                            input logic err, input bit bstart, input int feed_at, input int abort_at);
    int idx, bad, dones, done_c, err_at, nbits, lim, req_cyc;
    logic [1:0] ln;
    idx    = 0;
    bad    = 0;
    dones  = 0;
    done_c = -1;
    err_at = -1;
    build(nsend);
    nbits   = exp_q.size();
    lim     = nbits * BK + 20;
    req_cyc = (cyc < 0) ? nbits * BK : cyc;
    @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int c = 0; c < lim; c++) begin
      ln = {dplus_out, dminus_out};
      if (c == abort_at) begin
        n_rst = 1'b1;
        tx_data_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        check({name, " abort lines"}, int'({dplus_out, dminus_out}), 2);
        check({name, " abort busy"}, int'(tx_busy), 0);
        check({name, " abort ready"}, int'(tx_data_ready), 1);
        check({name, " abort done"}, int'(tx_done), 0);
        check({name, " abort error"}, int'(tx_error), 0);
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if ({dplus_out, dminus_out} != 2'b10 || tx_done || tx_busy) bad++;
        end
        check({name, " after abort quiet"}, bad, 0);
        return;
      end
      if (c < nbits * BK) begin
        if (ln != exp_q[c / BK] || !tx_busy) bad++;
        if (c % BK == BK - 1) begin
          check($sformatf("%s bit%0d", name, c / BK), bad, 0);
          bad = 0;
        end
      end
      if (tx_done) begin
        dones++;
        if (done_c < 0) begin
          done_c = c;
          err_at = int'(tx_error);
        end
      end
      tx_start = bstart && c == 100;
      if (c >= feed_at && idx < nsend) begin
        tx_data_valid = 1'b1;
        tx_data = pkt[idx];
        tx_last = (idx == n - 1);
        if (tx_data_ready) idx++;
      end else begin
        tx_data_valid = 1'b0;
      end
      @(negedge clk);
    end
    check({name, " done cycle"}, done_c, req_cyc);
    check({name, " done count"}, dones, 1);
    check({name, " error at done"}, err_at, int'(err));
    check({name, " end lines"}, int'({dplus_out, dminus_out}), 2);
    check({name, " end busy"}, int'(tx_busy), 0);
    check({name, " end ready"}, int'(tx_data_ready), 1);
  endtask

  initial begin
    int bad, n, ns;
    vt[0] = '{"c3",      1, 8'hC3, 8'h00, 8'h00, 1, 152, 1'b0, 1'b0};
    vt[1] = '{"ff_ff",   2, 8'hFF, 8'hFF, 8'h00, 2, 232, 1'b0, 1'b0};
    vt[2] = '{"underrun",2, 8'h4B, 8'h12, 8'h00, 1, 152, 1'b1, 1'b0};
    vt[3] = '{"busy_st", 1, 8'hA5, 8'h00, 8'h00, 1, 152, 1'b0, 1'b1};
    vt[4] = '{"fc_tail", 1, 8'hFC, 8'h00, 8'h00, 1, 160, 1'b0, 1'b0};
    vt[5] = '{"7f",      1, 8'h7F, 8'h00, 8'h00, 1, 160, 1'b0, 1'b0};
    vt[6] = '{"ff_x3",   3, 8'hFF, 8'hFF, 8'hFF, 3, 312, 1'b0, 1'b0};
    vt[7] = '{"zeros",   2, 8'h00, 8'h00, 8'h00, 2, 216, 1'b0, 1'b0};
    vt[8] = '{"no_byte", 1, 8'h55, 8'h00, 8'h00, 0, 88,  1'b1, 1'b0};
    repeat (3) @(negedge clk);
    check("rst lines", int'({dplus_out, dminus_out}), 2);
    check("rst busy", int'(tx_busy), 0);
    check("rst ready", int'(tx_data_ready), 1);
    check("rst done", int'(tx_done), 0);
    check("rst error", int'(tx_error), 0);
    n_rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ({dplus_out, dminus_out} != 2'b10 || tx_busy || !tx_data_ready || tx_done || tx_error) bad++;
    end
    check("idle20", bad, 0);
    for (int i = 0; i < 9; i++) begin
      pkt[0] = vt[i].b0;
      pkt[1] = vt[i].b1;
      pkt[2] = vt[i].b2;
      run_packet(vt[i].name, vt[i].n, vt[i].nsend, vt[i].cyc, vt[i].err, vt[i].bstart, 0, -1);
    end
    pkt[0] = 8'h11;
    pkt[1] = 8'h22;
    pkt[2] = 8'h33;
    run_packet("abort", 3, 3, -1, 1'b0, 1'b0, 0, 8 * 16 + 20);
    pkt[0] = 8'hA5;
    run_packet("post_abort", 1, 1, 152, 1'b0, 1'b0, 0, -1);
    for (int r = 0; r < 6; r++) begin
      n  = int'($urandom_range(1, 4));
      ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : n;
      for (int k = 0; k < n; k++) pkt[k] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      run_packet($sformatf("rnd%0d", r), n, ns, -1, ns < n, 1'b0, int'($urandom_range(0, 60)), -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/usb_tx_encoder.md
USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 Parameter BIT_CLKS, default 8, clk cycles per USB bit time (legal range 4..15).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 n_rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 tx_start  input  1  one-cycle pulse requesting a packet; honoured only in IDLE.
REQ-005 tx_data  input  8  packet byte (PID, payload, CRC bytes supplied by upstream AHB buffer).
REQ-006 tx_data_valid  input  1  tx_data holds a byte.
REQ-007 tx_last  input  1  qualifies tx_data as final byte of packet.
REQ-008 tx_data_ready  output  1  holding register empty; byte accepted when valid&&ready.
REQ-009 tx_busy  output  1  high from accepted tx_start until EOP complete.
REQ-010 tx_done  output  1  one-cycle pulse on return to IDLE.
REQ-011 tx_error  output  1  one-cycle pulse, coincident with tx_done, when packet ended by underrun.
REQ-012 dplus_out, dminus_out  output  1 each  full-speed line drive.

Function
REQ-013 States: IDLE, SYNC, DATA, EOP_SE0, EOP_J; one state transition per bit boundary except IDLE exit.
REQ-014 IDLE drives J (dplus=1, dminus=0), tx_busy=0, tx_data_ready=1.
REQ-015 tx_start in IDLE -> SYNC next cycle; first SYNC bit appears on lines that same cycle; tx_start outside IDLE ignored.
REQ-016 Every line bit (data or stuffed) held exactly BIT_CLKS cycles.
REQ-017 SYNC sends 8'h80 LSB first (seven 0s then one 1), NRZI-encoded from J, giving KJKJKJKK.
REQ-018 NRZI: bit 0 toggles J<->K; bit 1 holds current level.
REQ-019 DATA sends each byte LSB first; next byte loaded from holding register at byte boundary with no gap.
REQ-020 Bit stuffing: after six consecutive 1s an extra 0 is inserted; ones counter spans SYNC final 1 and byte boundaries, clears on any 0 (including stuffed).
REQ-021 Stuffed bit inserted even if sixth 1 is last bit of tx_last byte, before EOP.
REQ-022 Holding register: one byte; tx_data_ready=1 when empty; cleared (ready=1) in the cycle its byte moves to shifter.
REQ-023 First byte may be offered during SYNC; it must be present by SYNC end.
REQ-024 Underrun: byte boundary reached, previous byte not tx_last, holding empty -> EOP_SE0 and flag error.
REQ-025 After tx_last byte (and any stuff bit) -> EOP_SE0: dplus=0, dminus=0 for 2 bit times.
REQ-026 EOP_J: J for 1 bit time, then IDLE with tx_done (and tx_error if flagged) pulsed in the IDLE-entry cycle.
REQ-027 valid while busy with ready=0 holds off; upstream keeps tx_data stable until accepted.
REQ-028 Total line time = (8 + 8*N + stuffed bits + 3) * BIT_CLKS cycles for N bytes.

Reset
REQ-029 n_rst=1 at any time, including mid-packet: next edge state=IDLE, lines J, tx_busy=0, tx_data_ready=1, tx_done=0, tx_error=0, bit timer=0, ones counter=0, holding register empty, error flag cleared.
REQ-030 No EOP generated for a packet aborted by reset.

Structure
REQ-031 Package usb_tx_pkg holds state enum, SYNC_BYTE=8'h80, STUFF_LIMIT=6, EOP_SE0_BITS=2.
REQ-032 One sub-module usb_tx_bit_timer: counts 0..BIT_CLKS-1, emits bit_strobe on last count, cleared in IDLE.
REQ-033 NRZI, stuffing, shifter and holding register stay in usb_tx_encoder.

Verification
REQ-034 Reset, idle 20 cycles -> dplus=1, dminus=0, ready=1, busy=0, done never pulsed.
REQ-035 start, one byte 8'hC3 last -> SYNC KJKJKJKK, NRZI of C3 LSB first, SE0 16 cycles, J 8 cycles, done at cycle 8*(8+8+3)=152.
REQ-036 bytes 8'hFF,8'hFF last -> stuffed 0 after 5 data 1s (SYNC 1 counts), 2 stuffs, total (8+16+2+3)*8=232 cycles, error=0.
REQ-037 bytes 8'h4B,8'h12, valid withheld after first -> SE0 after 4B, done and tx_error pulse together.
REQ-038 n_rst asserted mid-DATA byte 2 -> J next cycle, busy=0, no SE0, subsequent clean packet 8'hA5 correct.
REQ-039 tx_start pulsed while busy -> ignored; only one done pulse.
